// File: rtl/fb_swap_controller_if.sv
// Producer/display handshake bundle for the frame-buffer swap controller.
// The master side drives the producer pulses and vsync; the slave side is the controller.
interface fb_swap_controller_if #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int CNT_BITS       = 16
);
  logic                      wr_issue;
  logic                      wr_resp;
  logic                      frame_done;
  logic                      vsync;
  logic                      prod_ready;
  logic                      prod_restart;
  logic [1:0]                prod_buf;
  logic [AXI_ADDR_WIDTH-1:0] prod_base;
  logic [1:0]                cons_buf;
  logic [AXI_ADDR_WIDTH-1:0] cons_base;
  logic                      swap;
  logic                      disp_enable;
  logic [CNT_BITS-1:0]       drop_cnt;
  logic [CNT_BITS-1:0]       repeat_cnt;
  logic                      wr_overflow;

  modport master (
    output wr_issue, wr_resp, frame_done, vsync,
    input  prod_ready, prod_restart, prod_buf, prod_base, cons_buf, cons_base,
           swap, disp_enable, drop_cnt, repeat_cnt, wr_overflow
  );

  modport slave (
    input  wr_issue, wr_resp, frame_done, vsync,
    output prod_ready, prod_restart, prod_buf, prod_base, cons_buf, cons_base,
           swap, disp_enable, drop_cnt, repeat_cnt, wr_overflow
  );
endinterface

// File: rtl/fb_swap_controller.sv
// Frame-buffer ownership controller: tracks producer/display buffers, drains AXI writes
// before publishing a frame and swaps the display buffer on vsync falling edges.
module fb_swap_controller #(
  parameter int NUM_BUFS        = 2,
  parameter int BUF_WORDS       = 307200,
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_BITS        = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  fb_swap_controller_if.slave bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [1:0] PEND_RST = (NUM_BUFS > 2) ? 2'd2 : 2'd0;

  typedef enum logic [1:0] {
    PRODUCE   = 2'd0,
    DRAIN     = 2'd1,
    PUBLISH   = 2'd2,
    WAIT_SWAP = 2'd3
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [OW-1:0]             outst_r, outst_nxt_s;
  logic [1:0]                prod_buf_r, prod_buf_nxt_s;
  logic [1:0]                cons_buf_r, cons_buf_nxt_s;
  logic [1:0]                pend_buf_r, pend_buf_nxt_s;
  logic                      pend_valid_r, pend_valid_nxt_s;
  logic                      disp_r, disp_nxt_s;
  logic [CNT_BITS-1:0]       drop_r, drop_nxt_s;
  logic [CNT_BITS-1:0]       repeat_r, repeat_nxt_s;
  logic                      ovf_r, ovf_nxt_s;
  logic                      vsync_hist_r;
  logic                      prod_ready_r, prod_ready_nxt_s;
  logic                      restart_r, restart_s;
  logic                      swap_r, swap_s;
  logic [AXI_ADDR_WIDTH-1:0] prod_base_r, cons_base_r;
  logic                      resp_eff_s, trigger_s, swap_now_s;

  function automatic logic [AXI_ADDR_WIDTH-1:0] base_of(input logic [1:0] idx);
    logic [63:0] full;
    full = 64'(BUF_WORDS) * {62'd0, idx};
    return full[AXI_ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    if (v == {CNT_BITS{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_BITS'(1);
    end
  endfunction

  // Lowest buffer index owned by neither a nor b.
  function automatic logic [1:0] lowest_free(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] res;
    logic       found;
    res   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (!found && (2'(i) != a) && (2'(i) != b)) begin
        res   = 2'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Next-state and next-value logic for the FSM, ownership and statistics.
  always_comb begin
    state_nxt_s      = state_r;
    outst_nxt_s      = outst_r;
    prod_buf_nxt_s   = prod_buf_r;
    cons_buf_nxt_s   = cons_buf_r;
    pend_buf_nxt_s   = pend_buf_r;
    pend_valid_nxt_s = pend_valid_r;
    disp_nxt_s       = disp_r;
    drop_nxt_s       = drop_r;
    repeat_nxt_s     = repeat_r;
    ovf_nxt_s        = ovf_r;
    restart_s        = 1'b0;
    swap_s           = 1'b0;

    resp_eff_s = bus.wr_resp && (outst_r != {OW{1'b0}});
    if (bus.wr_issue && !resp_eff_s && (outst_r != MAX_OUT)) begin
      outst_nxt_s = outst_r + OW'(1);
    end else if (!bus.wr_issue && resp_eff_s) begin
      outst_nxt_s = outst_r - OW'(1);
    end else begin
      outst_nxt_s = outst_r;
    end

    if (bus.wr_issue && (outst_r == MAX_OUT)) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    // Trigger decisions use pend_valid as registered before this cycle.
    trigger_s  = (vsync_hist_r && !bus.vsync) || (!disp_r && pend_valid_r);
    swap_now_s = trigger_s && pend_valid_r;

    if (trigger_s && !pend_valid_r && disp_r) begin
      repeat_nxt_s = sat_inc(repeat_r);
    end else begin
      repeat_nxt_s = repeat_r;
    end

    if (swap_now_s) begin
      cons_buf_nxt_s   = pend_buf_r;
      pend_valid_nxt_s = 1'b0;
      disp_nxt_s       = 1'b1;
      swap_s           = 1'b1;
      if (NUM_BUFS == 2) begin
        prod_buf_nxt_s = cons_buf_r;
        restart_s      = 1'b1;
      end else begin
        prod_buf_nxt_s = prod_buf_r;
      end
    end else begin
      cons_buf_nxt_s = cons_buf_r;
    end

    case (state_r)
      PRODUCE: begin
        if (bus.frame_done) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = PRODUCE;
        end
      end
      DRAIN: begin
        if (outst_r == {OW{1'b0}}) begin
          state_nxt_s = PUBLISH;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      PUBLISH: begin
        pend_valid_nxt_s = 1'b1;
        pend_buf_nxt_s   = prod_buf_r;
        if (NUM_BUFS >= 3) begin
          // A pending frame not taken by a same-cycle swap is overwritten.
          if (pend_valid_r && !swap_now_s) begin
            drop_nxt_s = sat_inc(drop_r);
          end else begin
            drop_nxt_s = drop_r;
          end
          prod_buf_nxt_s = lowest_free(cons_buf_nxt_s, prod_buf_r);
          restart_s      = 1'b1;
          state_nxt_s    = PRODUCE;
        end else begin
          state_nxt_s = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (swap_now_s) begin
          state_nxt_s = PRODUCE;
        end else begin
          state_nxt_s = WAIT_SWAP;
        end
      end
      default: begin
        state_nxt_s = PRODUCE;
      end
    endcase

    prod_ready_nxt_s = (state_nxt_s == PRODUCE) && (outst_nxt_s < MAX_OUT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= PRODUCE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outst_r      <= {OW{1'b0}};
      prod_buf_r   <= 2'd1;
      cons_buf_r   <= 2'd0;
      pend_buf_r   <= PEND_RST;
      pend_valid_r <= 1'b0;
      disp_r       <= 1'b0;
      drop_r       <= {CNT_BITS{1'b0}};
      repeat_r     <= {CNT_BITS{1'b0}};
      ovf_r        <= 1'b0;
      vsync_hist_r <= 1'b1;
      prod_ready_r <= 1'b0;
      restart_r    <= 1'b0;
      swap_r       <= 1'b0;
      prod_base_r  <= base_of(2'd1);
      cons_base_r  <= base_of(2'd0);
    end else begin
      outst_r      <= outst_nxt_s;
      prod_buf_r   <= prod_buf_nxt_s;
      cons_buf_r   <= cons_buf_nxt_s;
      pend_buf_r   <= pend_buf_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      disp_r       <= disp_nxt_s;
      drop_r       <= drop_nxt_s;
      repeat_r     <= repeat_nxt_s;
      ovf_r        <= ovf_nxt_s;
      vsync_hist_r <= bus.vsync;
      prod_ready_r <= prod_ready_nxt_s;
      restart_r    <= restart_s;
      swap_r       <= swap_s;
      prod_base_r  <= base_of(prod_buf_nxt_s);
      cons_base_r  <= base_of(cons_buf_nxt_s);
    end
  end

  assign bus.prod_ready   = prod_ready_r;
  assign bus.prod_restart = restart_r;
  assign bus.prod_buf     = prod_buf_r;
  assign bus.prod_base    = prod_base_r;
  assign bus.cons_buf     = cons_buf_r;
  assign bus.cons_base    = cons_base_r;
  assign bus.swap         = swap_r;
  assign bus.disp_enable  = disp_r;
  assign bus.drop_cnt     = drop_r;
  assign bus.repeat_cnt   = repeat_r;
  assign bus.wr_overflow  = ovf_r;

endmodule
